// File: rtl/vga_sync_gen.sv
// 640x480 VGA raster timing generator: sync pulses, position counters, active flag.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       CLK,
  input  logic       i_Rst_N,
  input  logic       i_Pix_En,
  output logic       o_H_Sync,
  output logic       o_V_Sync,
  output logic [9:0] o_CountCol,
  output logic [9:0] o_CountRow,
  output logic       o_Active,
  output logic       o_Frame_Start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] o_Frame_Count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] col_nxt;
  logic [9:0] row_nxt;
  logic       h_sync_on;
  logic       v_sync_on;
  logic       active_nxt;
  logic       frame_nxt;

  // Outputs are decoded from the next position so every registered output
  // lines up with the counters on the same edge.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_nxt = o_CountCol + 10'd1;
    row_nxt = o_CountRow;
    if (o_CountCol == H_LAST) begin
      col_nxt = '0;
      row_nxt = (o_CountRow == V_LAST) ? '0 : o_CountRow + 10'd1;
    end
    h_sync_on  = (col_nxt >= H_SYNC_BEG) && (col_nxt < H_SYNC_END);
    v_sync_on  = (row_nxt >= V_SYNC_BEG) && (row_nxt < V_SYNC_END);
    active_nxt = (col_nxt < H_ACT) && (row_nxt < V_ACT);
    frame_nxt  = (col_nxt == '0) && (row_nxt == '0);
  end

  // NOTE: state registers use non-blocking assignments so all outputs update together.
  always_ff @(posedge CLK) begin
    if (!i_Rst_N) begin
      o_CountCol    <= H_LAST;
      o_CountRow    <= V_LAST;
      o_H_Sync      <= ~SYNC_POL;
      o_V_Sync      <= ~SYNC_POL;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Frame_Start <= 1'b0;
      if (i_Pix_En) begin
        o_CountCol    <= col_nxt;
        o_CountRow    <= row_nxt;
        o_H_Sync      <= h_sync_on ? SYNC_POL : ~SYNC_POL;
        o_V_Sync      <= v_sync_on ? SYNC_POL : ~SYNC_POL;
        o_Active      <= active_nxt;
        o_Frame_Start <= frame_nxt;
      end
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge CLK) begin
    if (!i_Rst_N) begin
      o_Frame_Count <= '0;
    end else if (i_Pix_En && frame_nxt) begin
      o_Frame_Count <= o_Frame_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a default-size instance for reset and line timing,
// and a reduced-size instance (active-high sync) for frame-level, random and corner checks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } tim_t;

  typedef struct {
    bit   rst_n;
    bit   en;
    obs_t exp;
  } vec_t;

  tim_t d_t = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  tim_t s_t = '{8, 2, 3, 2, 5, 1, 2, 1, 1'b1};

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst_n, d_en, d_hs, d_vs, d_act, d_fs;
  logic [9:0] d_col, d_row;
  logic       s_rst_n, s_en, s_hs, s_vs, s_act, s_fs;
  logic [9:0] s_col, s_row;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] d_cnt, s_cnt;
`endif

  vga_sync_gen u_dut_def (
    .CLK          (clk),
    .i_Rst_N      (d_rst_n),
    .i_Pix_En     (d_en),
    .o_H_Sync     (d_hs),
    .o_V_Sync     (d_vs),
    .o_CountCol   (d_col),
    .o_CountRow   (d_row),
    .o_Active     (d_act),
    .o_Frame_Start(d_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .o_Frame_Count(d_cnt)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1)
  ) u_dut_small (
    .CLK          (clk),
    .i_Rst_N      (s_rst_n),
    .i_Pix_En     (s_en),
    .o_H_Sync     (s_hs),
    .o_V_Sync     (s_vs),
    .o_CountCol   (s_col),
    .o_CountRow   (s_row),
    .o_Active     (s_act),
    .o_Frame_Start(s_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .o_Frame_Count(s_cnt)
`endif
  );

  // Reference model: position is a linear pixel index within the frame.
  int d_p, s_p;
  bit d_mfs, s_mfs;

  function automatic int frame_len(input tim_t t);
    return (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
  endfunction

  function automatic obs_t model(input tim_t t, input int p, input bit fs);
    obs_t m;
    int   ht = t.ha + t.hf + t.hs + t.hb;
    int   c  = p % ht;
    int   r  = p / ht;
    m.col = 10'(c);
    m.row = 10'(r);
    m.hs  = (c >= t.ha + t.hf && c < t.ha + t.hf + t.hs) ? t.pol : !t.pol;
    m.vs  = (r >= t.va + t.vf && r < t.va + t.vf + t.vs) ? t.pol : !t.pol;
    m.act = (c < t.ha) && (r < t.va);
    m.fs  = fs;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick_d(input bit rst_n, input bit en);
    d_rst_n = rst_n;
    d_en    = en;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      d_p = frame_len(d_t) - 1; d_mfs = 0;
    end else if (en) begin
      d_p = (d_p + 1) % frame_len(d_t); d_mfs = (d_p == 0);
    end else begin
      d_mfs = 0;
    end
  endtask

  task automatic tick_s(input bit rst_n, input bit en);
    s_rst_n = rst_n;
    s_en    = en;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      s_p = frame_len(s_t) - 1; s_mfs = 0;
    end else if (en) begin
      s_p = (s_p + 1) % frame_len(s_t); s_mfs = (s_p == 0);
    end else begin
      s_mfs = 0;
    end
  endtask

  function automatic obs_t d_obs();
    return {d_col, d_row, d_hs, d_vs, d_act, d_fs};
  endfunction

  function automatic obs_t s_obs();
    return {s_col, s_row, s_hs, s_vs, s_act, s_fs};
  endfunction

  initial begin
    vec_t vecs[11];
    int   hs_low, hs_first, act_fall, vs_cnt, act_cnt, fs_seen, fs_first, fs_second;

    d_rst_n = 1'b0; d_en = 1'b0; s_rst_n = 1'b0; s_en = 1'b0;
    d_p = 0; s_p = 0; d_mfs = 0; s_mfs = 0;

    // Default instance: reset and first ticks, expected values written out by hand.
    vecs[0]  = '{1'b0, 1'b1, '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{1'b0, 1'b1, '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{1'b0, 1'b1, '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{1'b1, 1'b1, '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1}};
    vecs[4]  = '{1'b1, 1'b0, '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[5]  = '{1'b1, 1'b1, '{10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[6]  = '{1'b1, 1'b1, '{10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[7]  = '{1'b1, 1'b0, '{10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[8]  = '{1'b0, 1'b0, '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{1'b1, 1'b0, '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{1'b1, 1'b1, '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1}};
    for (int i = 0; i < 11; i++) begin
      tick_d(vecs[i].rst_n, vecs[i].en);
      check($sformatf("vec%0d", i), 32'(d_obs()), 32'(vecs[i].exp));
    end

    // Two full lines at full rate: model comparison plus explicit hsync/active edges.
    hs_low = 0; hs_first = -1; act_fall = -1;
    for (int i = 0; i < 1600; i++) begin
      tick_d(1'b1, 1'b1);
      check("line_model", 32'(d_obs()), 32'(model(d_t, d_p, d_mfs)));
      if (d_row == 10'd0 && d_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_col);
      end
      if (d_row == 10'd0 && d_act == 1'b0 && act_fall < 0) act_fall = int'(d_col);
    end
    check("hsync_low_width", 32'(hs_low), 32'd96);
    check("hsync_first_col", 32'(hs_first), 32'd656);
    check("active_fall_col", 32'(act_fall), 32'd640);
    d_en = 1'b0;

    // Reduced instance: one full frame, vertical sync and active totals.
    tick_s(1'b0, 1'b1);
    check("small_reset", 32'(s_obs()), 32'({10'd14, 10'd8, 1'b0, 1'b0, 1'b0, 1'b0}));
    vs_cnt = 0; act_cnt = 0;
    for (int i = 0; i < 135; i++) begin
      tick_s(1'b1, 1'b1);
      check("frame_model", 32'(s_obs()), 32'(model(s_t, s_p, s_mfs)));
      if (s_vs) vs_cnt++;
      if (s_act) act_cnt++;
    end
    check("vsync_ticks", 32'(vs_cnt), 32'd30);
    check("active_ticks", 32'(act_cnt), 32'd40);

    // Enable toggling 1,0,1,0: frame-start spacing doubles, pulse stays one CLK.
    tick_s(1'b0, 1'b0);
    fs_seen = 0; fs_first = -1; fs_second = -1;
    for (int i = 0; i < 1000 && fs_seen < 2; i++) begin
      tick_s(1'b1, (i % 2) == 0);
      check("gate_model", 32'(s_obs()), 32'(model(s_t, s_p, s_mfs)));
      if (s_fs) begin
        if (fs_seen == 0) fs_first = i; else fs_second = i;
        fs_seen++;
      end
    end
    check("gate_fs_found", 32'(fs_seen), 32'd2);
    check("gate_fs_spacing", 32'(fs_second - fs_first), 32'd270);
    tick_s(1'b1, 1'b0);
    check("gate_fs_width", 32'(s_fs), 32'd0);

    // Mid-frame reset at (5,3) returns to the last pixel, next tick starts a frame.
    tick_s(1'b0, 1'b0);
    for (int i = 0; i < 51; i++) tick_s(1'b1, 1'b1);
    check("mid_pos", 32'({s_col, s_row}), 32'({10'd5, 10'd3}));
    tick_s(1'b0, 1'b1);
    check("mid_reset", 32'(s_obs()), 32'({10'd14, 10'd8, 1'b0, 1'b0, 1'b0, 1'b0}));
    tick_s(1'b1, 1'b1);
    check("mid_restart", 32'(s_obs()), 32'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1}));

    // Randomized enable and occasional reset against the model.
    for (int i = 0; i < 3000; i++) begin
      tick_s($urandom_range(0, 99) != 0, 1'($urandom));
      check("rand_model", 32'(s_obs()), 32'(model(s_t, s_p, s_mfs)));
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter: 1 after the first start, 255 at the 255th, wraps to 0 at the 256th.
    tick_s(1'b0, 1'b1);
    check("cnt_reset", 32'(s_cnt), 32'd0);
    tick_s(1'b1, 1'b1);
    check("cnt_first", 32'(s_cnt), 32'd1);
    tick_s(1'b1, 1'b0);
    check("cnt_hold", 32'(s_cnt), 32'd1);
    for (int f = 2; f <= 256; f++) begin
      for (int i = 0; i < 135; i++) tick_s(1'b1, 1'b1);
      if (f == 255) check("cnt_255", 32'(s_cnt), 32'd255);
    end
    check("cnt_wrap", 32'({s_cnt, 7'd0, s_fs}), 32'({8'd0, 7'd0, 1'b1}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
